// File: rtl/au_pkg.sv
// Shared definitions for the fixed-point arithmetic unit and its downstream stages.
package au_pkg;

    // Default operand widths, shared with the au so both sides agree on the format.
    localparam int unsigned AU_WIDTH_1 = 4;
    localparam int unsigned AU_WIDTH_2 = 4;
    localparam int unsigned AU_ACC_LEN = 4;

    // Accumulator control states.
    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } acc_state_e;

    // Total fixed-point width {int,frac}.
    function automatic int unsigned fx_width(input int unsigned w1, input int unsigned w2);
        return w1 + w2;
    endfunction

    // Width needed to hold a beat count in the range 0..n.
    function automatic int unsigned cnt_width(input int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/au_sat_add.sv
// Unsigned W-bit saturating adder; clamps to all-ones on carry out.
module au_sat_add #(
    parameter int unsigned W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum,
    output logic         sat
);

    logic [W:0] w_full;

    // Widened sum so the carry is visible, then clamp on carry.
    always_comb begin
        w_full = {1'b0, a} + {1'b0, b};
        sat    = w_full[W];
        sum    = w_full[W] ? {W{1'b1}} : w_full[W-1:0];
    end

endmodule

// File: rtl/au_result_accum.sv
// Block accumulator for au results: sums up to ACC_LEN beats (or fewer on flush)
// with saturation and presents the registered result on a valid/ready port.
module au_result_accum
    import au_pkg::*;
#(
    parameter  int unsigned WIDTH_1 = AU_WIDTH_1,
    parameter  int unsigned WIDTH_2 = AU_WIDTH_2,
    parameter  int unsigned ACC_LEN = AU_ACC_LEN,
    localparam int unsigned W       = fx_width(WIDTH_1, WIDTH_2),
    localparam int unsigned CW      = cnt_width(ACC_LEN)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH_1-1:0] in_int,
    input  logic [WIDTH_2-1:0] in_frac,
    input  logic               in_overflow,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH_1-1:0] out_int,
    output logic [WIDTH_2-1:0] out_frac,
    output logic               out_overflow,
    output logic               out_zero,
    output logic [CW-1:0]      out_count
);

    acc_state_e r_state;
    acc_state_e w_state_next;

    logic [W-1:0]       r_acc;
    logic [CW-1:0]      r_count;
    logic               r_sticky;

    logic [WIDTH_1-1:0] r_out_int;
    logic [WIDTH_2-1:0] r_out_frac;
    logic               r_out_overflow;
    logic               r_out_zero;
    logic [CW-1:0]      r_out_count;

    logic [W-1:0]       w_beat;
    logic [W-1:0]       w_sum;
    logic               w_sat;
    logic               w_accept;
    logic               w_block_end;
    logic [W-1:0]       w_acc_fin;
    logic [CW-1:0]      w_cnt_fin;
    logic               w_sticky_fin;

    assign w_beat = {in_int, in_frac};

    au_sat_add #(
        .W (W)
    ) u_sat_add (
        .a   (r_acc),
        .b   (w_beat),
        .sum (w_sum),
        .sat (w_sat)
    );

    // Post-beat accumulator values and block-termination decision for this cycle.
    always_comb begin
        w_accept     = in_valid & (r_state == ACCUM);
        w_acc_fin    = r_acc;
        w_cnt_fin    = r_count;
        w_sticky_fin = r_sticky;
        w_block_end  = 1'b0;
        if (w_accept) begin
            w_acc_fin    = w_sum;
            w_cnt_fin    = r_count + CW'(1);
            w_sticky_fin = r_sticky | in_overflow | w_sat;
        end
        if (r_state == ACCUM) begin
            if (w_accept) begin
                // A flushed beat is still part of the block it terminates.
                w_block_end = (w_cnt_fin == CW'(ACC_LEN)) | flush;
            end else begin
                // A flush with nothing accumulated is meaningless and ignored.
                w_block_end = flush & (r_count != '0);
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ACCUM;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: ACCUM until block end, HOLD until downstream takes the result.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ACCUM:   if (w_block_end) w_state_next = HOLD;
            HOLD:    if (out_ready)   w_state_next = ACCUM;
            default: w_state_next = ACCUM;
        endcase
    end

    // Handshake outputs decode the state register only, so no in_* to out_* path exists.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            ACCUM:   in_ready  = 1'b1;
            HOLD:    out_valid = 1'b1;
            default: in_ready  = 1'b0;
        endcase
    end

    // Running accumulator: updated on accepted beats, cleared when the result is consumed.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc    <= '0;
            r_count  <= '0;
            r_sticky <= 1'b0;
        end else if (r_state == ACCUM) begin
            if (w_accept) begin
                r_acc    <= w_acc_fin;
                r_count  <= w_cnt_fin;
                r_sticky <= w_sticky_fin;
            end
        end else if (out_ready) begin
            r_acc    <= '0;
            r_count  <= '0;
            r_sticky <= 1'b0;
        end
    end

    // Result registers: captured once at block end and held stable through HOLD.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_int      <= '0;
            r_out_frac     <= '0;
            r_out_overflow <= 1'b0;
            r_out_zero     <= 1'b0;
            r_out_count    <= '0;
        end else if (w_block_end) begin
            r_out_int      <= w_acc_fin[W-1 -: WIDTH_1];
            r_out_frac     <= w_acc_fin[WIDTH_2-1:0];
            r_out_overflow <= w_sticky_fin;
            r_out_zero     <= (w_acc_fin == '0);
            r_out_count    <= w_cnt_fin;
        end
    end

    assign out_int      = r_out_int;
    assign out_frac     = r_out_frac;
    assign out_overflow = r_out_overflow;
    assign out_zero     = r_out_zero;
    assign out_count    = r_out_count;

endmodule

// File: tb/tb_au_result_accum.sv
// Bench for au_result_accum: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a block-level sum model.
module tb_au_result_accum;

    localparam int W1   = 4;
    localparam int W2   = 4;
    localparam int AL   = 4;
    localparam int CW   = $clog2(AL + 1);
    localparam int MAXV = (1 << (W1 + W2)) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W1-1:0] in_int = '0;
    logic [W2-1:0] in_frac = '0;
    logic          in_overflow = 1'b0;
    logic          flush = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W1-1:0] out_int;
    logic [W2-1:0] out_frac;
    logic          out_overflow;
    logic          out_zero;
    logic [CW-1:0] out_count;

    int n_checks = 0;
    int n_fail   = 0;

    au_result_accum #(
        .WIDTH_1 (W1),
        .WIDTH_2 (W2),
        .ACC_LEN (AL)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_int       (in_int),
        .in_frac      (in_frac),
        .in_overflow  (in_overflow),
        .flush        (flush),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_int      (out_int),
        .out_frac     (out_frac),
        .out_overflow (out_overflow),
        .out_zero     (out_zero),
        .out_count    (out_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // A block is the plain integer sum of its beats; the result is that sum
    // clamped to the format maximum, and saturation happened iff the sum exceeded it.
    bit m_live = 0;
    bit m_after_rst = 0;
    bit m_hold = 0;
    int m_sum = 0;
    int m_cnt = 0;
    bit m_ovf = 0;
    int e_int = 0, e_frac = 0, e_cnt = 0;
    bit e_ovf = 0, e_zero = 0;

    always @(posedge clk) begin
        int val;
        if (rst) begin
            m_live = 1; m_after_rst = 1; m_hold = 0;
            m_sum = 0; m_cnt = 0; m_ovf = 0;
            e_int = 0; e_frac = 0; e_cnt = 0; e_ovf = 0; e_zero = 0;
        end else begin
            bit fin;
            m_after_rst = 0;
            fin = 0;
            if (!m_hold) begin
                if (in_valid) begin
                    m_sum += int'({in_int, in_frac});
                    m_cnt += 1;
                    m_ovf |= in_overflow;
                    fin = (m_cnt == AL) || flush;
                end else begin
                    fin = flush && (m_cnt > 0);
                end
                if (fin) begin
                    val    = (m_sum > MAXV) ? MAXV : m_sum;
                    e_int  = val / (1 << W2);
                    e_frac = val % (1 << W2);
                    e_ovf  = m_ovf || (m_sum > MAXV);
                    e_zero = (val == 0);
                    e_cnt  = m_cnt;
                    m_hold = 1;
                end
            end else if (out_ready) begin
                m_hold = 0; m_sum = 0; m_cnt = 0; m_ovf = 0;
            end
        end
    end

    // Compare process: handshake every cycle, result fields whenever they are defined.
    always @(negedge clk) begin
        if (m_live) begin
            check("in_ready", in_ready, !m_hold);
            check("out_valid", out_valid, m_hold);
            if (m_hold || m_after_rst) begin
                check("out_int", out_int, e_int);
                check("out_frac", out_frac, e_frac);
                check("out_overflow", out_overflow, e_ovf);
                check("out_zero", out_zero, e_zero);
                check("out_count", out_count, e_cnt);
            end
        end
    end

    // ---------------- directed helpers ----------------
    task automatic send(input int vi, input int vf, input bit ov, input bit fl);
        int n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 100) check("send_timeout", 0, 1);
        in_valid = 1; in_int = W1'(vi); in_frac = W2'(vf); in_overflow = ov; flush = fl;
        @(posedge clk); #1;
        in_valid = 0; in_overflow = 0; flush = 0;
    endtask

    task automatic expect_block(input int xi, input int xf, input bit xo, input bit xz, input int xc);
        int n = 0;
        while (!out_valid && n < 50) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 50) check("out_valid_timeout", 0, 1);
        check("lit_int", out_int, xi);
        check("lit_frac", out_frac, xf);
        check("lit_ovf", out_overflow, xo);
        check("lit_zero", out_zero, xz);
        check("lit_count", out_count, xc);
        out_ready = 1;
        @(posedge clk); #1;
        out_ready = 0;
        check("lit_ready_after_hs", in_ready, 1);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 0;
        check("lit_rst_in_ready", in_ready, 1);
        check("lit_rst_out_valid", out_valid, 0);
        check("lit_rst_out_count", out_count, 0);

        // Four beats of 1.5 -> 6.0.
        for (int i = 0; i < 4; i++) send(1, 8, 0, 0);
        check("lit_latency", out_valid, 1);
        expect_block(6, 0, 0, 0, 4);

        // 15.0 + 2.0 saturates; flushed with the second beat.
        send(15, 0, 0, 0);
        send(2, 0, 0, 1);
        expect_block(15, 15, 1, 0, 2);

        // Zeros with an overflow flag on beat 3.
        for (int i = 0; i < 4; i++) send(0, 0, i == 2, 0);
        expect_block(0, 0, 1, 1, 4);

        // Lone flush on an empty block is ignored; then 0.25 with flush.
        flush = 1;
        @(posedge clk); #1;
        flush = 0;
        check("lit_empty_flush_ready", in_ready, 1);
        check("lit_empty_flush_valid", out_valid, 0);
        send(0, 4, 0, 1);
        expect_block(0, 4, 0, 0, 1);

        // Downstream stall with upstream pushing: nothing consumed, outputs stable.
        for (int i = 0; i < 4; i++) send(1, 0, 0, 0);
        in_valid = 1; in_int = 3; in_frac = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("lit_stall_valid", out_valid, 1);
            check("lit_stall_ready", in_ready, 0);
            check("lit_stall_int", out_int, 4);
            check("lit_stall_count", out_count, 4);
        end
        out_ready = 1;
        @(posedge clk); #1;
        out_ready = 0; in_valid = 0;
        check("lit_stall_release", in_ready, 1);

        // Mid-block reset discards partial work.
        send(2, 0, 0, 0);
        send(3, 0, 1, 0);
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        check("lit_midrst_ready", in_ready, 1);
        check("lit_midrst_valid", out_valid, 0);
        check("lit_midrst_int", out_int, 0);
        check("lit_midrst_ovf", out_overflow, 0);
        for (int i = 0; i < 4; i++) send(1, 0, 0, 0);
        expect_block(4, 0, 0, 0, 4);

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            in_valid    = ($urandom % 3) != 0;
            in_int      = ($urandom % 4 == 0) ? W1'($urandom) : W1'($urandom % 3);
            in_frac     = W2'($urandom);
            in_overflow = ($urandom % 16) == 0;
            flush       = ($urandom % 8) == 0;
            out_ready   = ($urandom % 2) == 0;
            rst         = ($urandom % 300) == 0;
            @(posedge clk); #1;
        end
        in_valid = 0; flush = 0; in_overflow = 0; rst = 0; out_ready = 1;
        repeat (5) @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
